// File: rtl/obj_arb_pkg.sv
// rtl/obj_arb_pkg.sv - shared types for the object ID bus arbiter
// Contents:
//   OBJ_ID_W     default object ID width shared by cells and arbiter
//   obj_id_t     object ID type
//   arb_state_t  arbiter FSM states (IDLE, ARB, GRANT)
package obj_arb_pkg;

  localparam int OBJ_ID_W = 4;

  typedef logic [OBJ_ID_W-1:0] obj_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/obj_bus_arbiter_if.sv
// rtl/obj_bus_arbiter_if.sv - object ID bus request/grant interface
// Signals:
//   req[NUM_REQ]         per-cell bus request (level)
//   ids[NUM_REQ*ID_W]    per-cell IDs, cell i at [i*ID_W +: ID_W]
//   grant[NUM_REQ]       one-hot registered grant
//   grant_id[ID_W]       ID of current owner, 0 when idle
//   busy                 arbitration or grant in progress
//   bus_bit              resolved wired-AND bit, 1 outside arbitration
//   arb_done, collision  one-cycle pulses on the first grant cycle
// Modports: master = object cells side, slave = arbiter side.
interface obj_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4
);

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*ID_W-1:0] ids;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic                    bus_bit;
  logic                    arb_done;
  logic                    collision;

  modport master (
    output req, ids,
    input  grant, grant_id, busy, bus_bit, arb_done, collision
  );

  modport slave (
    input  req, ids,
    output grant, grant_id, busy, bus_bit, arb_done, collision
  );

endinterface

// File: rtl/obj_arb_contender.sv
// rtl/obj_arb_contender.sv - one object cell taking part in bitwise arbitration
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        snapshot req_bit into the active flag (round start)
//   req_bit     this cell's request
//   arb_en      arbitration cycle in progress
//   bitidx      ID bit currently on the bus
//   id          this cell's ID
//   bus_bit     resolved wired-AND bit
//   drive       bit this cell puts on the bus (1 = released)
//   keep        cell survives the current bit
module obj_arb_contender #(
  parameter int ID_W  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             req_bit,
  input  logic             arb_en,
  input  logic [IDX_W-1:0] bitidx,
  input  logic [ID_W-1:0]  id,
  input  logic             bus_bit,
  output logic             drive,
  output logic             keep
);

  logic active;

  // An inactive cell releases the line so it never affects the AND.
  assign drive = active ? id[bitidx] : 1'b1;

  // Released the line while someone else pulled it low: this cell lost.
  assign keep = active & ~(id[bitidx] & ~bus_bit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
    end else if (load) begin
      active <= req_bit;
    end else if (arb_en) begin
      active <= keep;
    end
  end

endmodule

// File: rtl/obj_bus_arbiter.sv
// rtl/obj_bus_arbiter.sv - wired-AND object ID bus arbiter, lowest ID wins
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    obj_bus_arbiter_if.slave (req, ids in; grant, grant_id, busy,
//          bus_bit, arb_done, collision out)
// Optional: define ARB_TIMEOUT_EN to force the grant off after HOLD_MAX
// grant cycles.
module obj_bus_arbiter
  import obj_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = OBJ_ID_W,
  parameter int HOLD_MAX = 16
) (
  input logic              clk,
  input logic              rst_n,
  obj_bus_arbiter_if.slave bus
);

  localparam int              IDX_W   = (ID_W > 1) ? $clog2(ID_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(ID_W - 1);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   bitidx, bitidx_n;
  logic [NUM_REQ-1:0] grant_r, grant_n;
  logic [ID_W-1:0]    gid_r, gid_n;
  logic               arb_done_r, arb_done_n;
  logic               coll_r, coll_n;
  logic               load, arb_en, bus_bit, hold_expired;
  logic [NUM_REQ-1:0] drive, keep, win_oh;
  logic [ID_W-1:0]    win_id;
  logic               multi;

  assign arb_en  = (state == ARB);
  assign bus_bit = arb_en ? &drive : 1'b1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cell
    obj_arb_contender #(.ID_W(ID_W), .IDX_W(IDX_W)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .req_bit (bus.req[i]),
      .arb_en  (arb_en),
      .bitidx  (bitidx),
      .id      (bus.ids[i*ID_W +: ID_W]),
      .bus_bit (bus_bit),
      .drive   (drive[i]),
      .keep    (keep[i])
    );
  end

  // Survivors after the last bit; descending scan leaves the lowest index.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (keep[i]) begin
        win_oh = NUM_REQ'(1) << i;
        win_id = bus.ids[i*ID_W +: ID_W];
      end
    end
    multi = ($countones(keep) > 1);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  logic [HOLD_W-1:0] hold_cnt;

  assign hold_expired = (hold_cnt == HOLD_W'(HOLD_MAX - 1));

  // Zero on grant entry, counts each grant cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || state != GRANT) hold_cnt <= '0;
    else                          hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign hold_expired = 1'b0;
  if (HOLD_MAX < 1) begin : g_hold_max_unused
  end
`endif

  always_comb begin
    state_n    = state;
    bitidx_n   = bitidx;
    grant_n    = grant_r;
    gid_n      = gid_r;
    arb_done_n = 1'b0;
    coll_n     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          load     = 1'b1;
          bitidx_n = IDX_TOP;
          state_n  = ARB;
        end
      end
      ARB: begin
        bitidx_n = bitidx - 1'b1;
        if (bitidx == '0) begin
          state_n    = GRANT;
          bitidx_n   = IDX_TOP;
          grant_n    = win_oh;
          gid_n      = win_id;
          arb_done_n = 1'b1;
          coll_n     = multi;
        end
      end
      GRANT: begin
        if (~|(bus.req & grant_r) || hold_expired) begin
          state_n = IDLE;
          grant_n = '0;
          gid_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitidx     <= IDX_TOP;
      grant_r    <= '0;
      gid_r      <= '0;
      arb_done_r <= 1'b0;
      coll_r     <= 1'b0;
    end else begin
      state      <= state_n;
      bitidx     <= bitidx_n;
      grant_r    <= grant_n;
      gid_r      <= gid_n;
      arb_done_r <= arb_done_n;
      coll_r     <= coll_n;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.grant_id  = gid_r;
  assign bus.busy      = (state != IDLE);
  assign bus.bus_bit   = bus_bit;
  assign bus.arb_done  = arb_done_r;
  assign bus.collision = coll_r;

endmodule

// File: tb/tb_obj_bus_arbiter.sv
// tb/tb_obj_bus_arbiter.sv - self-checking bench for obj_bus_arbiter
module tb_obj_bus_arbiter;
  import obj_arb_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 4;
  localparam int HOLD_MAX = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  typedef logic [NUM_REQ-1:0]      req_t;
  typedef logic [NUM_REQ*ID_W-1:0] ids_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obj_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  obj_bus_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  // Reference model: tracks the round by cycle count, picks the winner as
  // the minimum ID among the snapshot (lowest index on ties).
  int              m_mode = 0;   // 0 idle, 1 arbitrating, 2 granted
  int              m_cnt = 0;
  int              m_hold = 0;
  int              m_owner = 0;
  req_t            m_snap = '0;
  logic [ID_W-1:0] m_min = '0;
  req_t            e_grant = '0;
  logic [ID_W-1:0] e_gid = '0;
  logic            e_done = 1'b0;
  logic            e_coll = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", name, step_no, got, exp);
    end
  endtask

  task automatic model_edge(input req_t r, input ids_t idv, input logic rn);
    int n;
    e_done = 1'b0;
    e_coll = 1'b0;
    if (!rn) begin
      m_mode = 0; e_grant = '0; e_gid = '0;
    end else if (m_mode == 0) begin
      if (r != '0) begin
        m_mode = 1; m_cnt = 0; m_snap = r; m_min = '1;
        for (int i = 0; i < NUM_REQ; i++)
          if (r[i] && idv[i*ID_W +: ID_W] < m_min) m_min = idv[i*ID_W +: ID_W];
      end
    end else if (m_mode == 1) begin
      if (m_cnt == ID_W - 1) begin
        n = 0; m_owner = -1;
        for (int i = 0; i < NUM_REQ; i++)
          if (m_snap[i] && idv[i*ID_W +: ID_W] == m_min) begin
            n++;
            if (m_owner < 0) m_owner = i;
          end
        e_grant = req_t'(1) << m_owner;
        e_gid = m_min; e_done = 1'b1; e_coll = (n > 1);
        m_mode = 2; m_hold = 1;
      end else begin
        m_cnt++;
      end
    end else begin
      if (!r[m_owner] || (TIMEOUT && m_hold == HOLD_MAX)) begin
        m_mode = 0; e_grant = '0; e_gid = '0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic step(input req_t r, input ids_t idv, input logic rn);
    logic eb;
    bus.req = r;
    bus.ids = idv;
    rst_n = rn;
    @(posedge clk);
    model_edge(r, idv, rn);
    #1;
    step_no++;
    eb = (m_mode == 1) ? m_min[ID_W-1-m_cnt] : 1'b1;
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("grant_id", 32'(bus.grant_id), 32'(e_gid));
    chk("busy", 32'(bus.busy), 32'(m_mode != 0));
    chk("bus_bit", 32'(bus.bus_bit), 32'(eb));
    chk("arb_done", 32'(bus.arb_done), 32'(e_done));
    chk("collision", 32'(bus.collision), 32'(e_coll));
  endtask

  typedef struct {
    req_t            req;
    ids_t            ids;
    req_t            grant;
    logic [ID_W-1:0] gid;
    logic            coll;
  } vec_t;

  function automatic vec_t mk(input req_t r, input ids_t i, input req_t g,
                              input logic [ID_W-1:0] id, input logic c);
    vec_t v;
    v.req = r; v.ids = i; v.grant = g; v.gid = id; v.coll = c;
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d", step_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ids_t idv;
    req_t r;
    logic [ID_W-1:0] bbs;
    int n;

    // ids packed {cell3, cell2, cell1, cell0}
    tbl[0] = mk(4'b0011, {4'h0, 4'h0, 4'hD, 4'h5}, 4'b0001, 4'h5, 1'b0);
    tbl[1] = mk(4'b0011, {4'h0, 4'h0, 4'h5, 4'h5}, 4'b0001, 4'h5, 1'b1);
    tbl[2] = mk(4'b0100, {4'h0, 4'hF, 4'h0, 4'h0}, 4'b0100, 4'hF, 1'b0);
    tbl[3] = mk(4'b1111, {4'h8, 4'h3, 4'h7, 4'h9}, 4'b0100, 4'h3, 1'b0);
    tbl[4] = mk(4'b1010, {4'h0, 4'h1, 4'h0, 4'h2}, 4'b0010, 4'h0, 1'b1);
    tbl[5] = mk(4'b1001, {4'h2, 4'h0, 4'h0, 4'hE}, 4'b1000, 4'h2, 1'b0);

    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("reset_bus_bit", 32'(bus.bus_bit), 32'd1);
    step('0, '0, 1'b1);

    for (int v = 0; v < 6; v++) begin
      step(tbl[v].req, tbl[v].ids, 1'b1);
      for (int b = 0; b < ID_W; b++) begin
        bbs[ID_W-1-b] = bus.bus_bit;
        step(tbl[v].req, tbl[v].ids, 1'b1);
      end
      chk("tbl_bus_seq", 32'(bbs), 32'(tbl[v].gid));
      chk("tbl_grant", 32'(bus.grant), 32'(tbl[v].grant));
      chk("tbl_gid", 32'(bus.grant_id), 32'(tbl[v].gid));
      chk("tbl_coll", 32'(bus.collision), 32'(tbl[v].coll));
      chk("tbl_done", 32'(bus.arb_done), 32'd1);
      step('0, tbl[v].ids, 1'b1);
      step('0, tbl[v].ids, 1'b1);
    end

    // Release and rearbitrate
    idv = {4'h0, 4'h0, 4'hD, 4'h5};
    for (int i = 0; i < 5; i++) step(4'b0011, idv, 1'b1);
    chk("rel_first", 32'(bus.grant), 32'b0001);
    for (int i = 0; i < 9; i++) step(4'b0011, idv, 1'b1);
    step(4'b0010, idv, 1'b1);
    chk("rel_clear", 32'(bus.grant), 32'd0);
    for (int i = 0; i < 5; i++) step(4'b0010, idv, 1'b1);
    chk("rel_regrant", 32'(bus.grant), 32'b0010);
    chk("rel_regrant_id", 32'(bus.grant_id), 32'hD);
    step('0, idv, 1'b1);

    // Reset in the second arbitration cycle
    step(4'b0011, idv, 1'b1);
    step(4'b0011, idv, 1'b1);
    step(4'b0011, idv, 1'b0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bus_bit", 32'(bus.bus_bit), 32'd1);
    step(4'b0011, idv, 1'b1);
    chk("rst_restart", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) step(4'b0011, idv, 1'b1);
    chk("rst_grant", 32'(bus.grant), 32'b0001);
    step('0, idv, 1'b1);

    // Late lower-ID request is not part of the running round
    idv = {4'h0, 4'h0, 4'h0, 4'h5};
    step(4'b0001, idv, 1'b1);
    step(4'b0001, idv, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0011, idv, 1'b1);
    chk("late_grant", 32'(bus.grant), 32'b0001);
    step(4'b0010, idv, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0010, idv, 1'b1);
    chk("late_next", 32'(bus.grant), 32'b0010);
    step('0, idv, 1'b1);

    // Winner keeps requesting
    idv = {4'h0, 4'h0, 4'hD, 4'h5};
    for (int i = 0; i < 5; i++) step(4'b0011, idv, 1'b1);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      step(4'b0011, idv, 1'b1);
      if (bus.grant == '0) break;
      n++;
    end
`ifdef ARB_TIMEOUT_EN
    chk("timeout_len", 32'(n), 32'(HOLD_MAX));
    step(4'b0011, idv, 1'b1);
    chk("timeout_rearb", 32'(bus.busy), 32'd1);
`else
    chk("hold_forever", 32'(bus.grant), 32'b0001);
`endif
    for (int i = 0; i < 7; i++) step('0, idv, 1'b1);

    // Randomized traffic against the model
    for (int batch = 0; batch < 4; batch++) begin
      for (int i = 0; i < NUM_REQ; i++)
        idv[i*ID_W +: ID_W] = ($urandom_range(0, 5) == 0) ? 4'hF : ID_W'($urandom_range(0, 7));
      r = '0;
      for (int c = 0; c < 80; c++) begin
        for (int i = 0; i < NUM_REQ; i++)
          if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
        step(r, idv, ($urandom_range(0, 99) != 0));
      end
      for (int c = 0; c < 8; c++) step('0, idv, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obj_bus_arbiter.md
Name: obj_bus_arbiter

Overview:
Controller for the shared wired-AND (triand, pulled-up) object ID bus. Runs serial bitwise arbitration rounds among up to NUM_REQ object cells, MSB first. A requester drives its ID bit, a '1' releases the line, and the lowest ID wins. It then grants the bus to the winner until the winner releases. Wired-AND resolution is modelled internally as an AND-reduction, so the block is synthesizable; the resolved bit is exported for observation.

Parameters:
- NUM_REQ, 4: number of object cells contending.
- ID_W, 4: object ID width; arbitration length in cycles.
- HOLD_MAX, 16: maximum grant cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-cell bus request, level
- ids  in  NUM_REQ*ID_W  per-cell ID; cell i occupies [i*ID_W +: ID_W]
- grant  out  NUM_REQ  one-hot grant, registered
- grant_id  out  ID_W  ID of current owner, registered
- busy  out  1  high in ARB or GRANT
- bus_bit  out  1  resolved wired-AND bit of the current ARB cycle; 1 when not in ARB
- arb_done  out  1  one-cycle pulse on the first GRANT cycle
- collision  out  1  one-cycle pulse with arb_done when more than one survivor remains (duplicate IDs)

Behaviour:
- Reset (rst_n low at a clock edge) takes effect at any state, including mid-round. After reset: state=IDLE, grant=0, grant_id=0, busy=0, bus_bit=1, arb_done=0, collision=0, active=0, bit index=ID_W-1.
- FSM states: IDLE, ARB, GRANT.
- IDLE: if |req at edge k, snapshot active<=req, bit index<=ID_W-1, go to ARB. Requests arriving later wait for the next round.
- ARB (cycles k+1 .. k+ID_W):
  - bus_bit = AND over active cells of ids[i][bitidx]; bus_bit=1 if no cell is active.
  - At each edge, cell i is cleared from active if its bit is 1 and bus_bit is 0.
  - bitidx decrements by 1 per cycle; on bitidx==0 go to GRANT.
  - req changes during ARB are ignored; the snapshot governs the round.
- Entry to GRANT:
  - Winner is the lowest-index cell still active.
  - grant is one-hot of the winner; grant_id is the winner's ID; arb_done pulses.
  - collision pulses if popcount(active)>1.
  - Grant is first visible at edge k+ID_W+1. Latency from req sampled to grant = ID_W+1 cycles.
- GRANT: hold while req[winner]=1. When req[winner]=0 is sampled, go to IDLE. grant and grant_id clear on that same edge; grant_id reads 0 when idle.
- From IDLE, a new round may start on the edge after release, giving a minimum one idle cycle between grants.
- Only one requester: that requester still runs the full ID_W-cycle round, with no shortcut.
- ID all-ones with no other contender: wins, bus_bit=1 throughout.
- A winner whose req dropped during ARB: still granted for exactly one cycle, then returns to IDLE.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a hold counter starts at GRANT entry. After HOLD_MAX grant cycles, the FSM forcibly returns to IDLE and clears grant, even if req[winner] is still high. The preempted cell rejoins the next round normally.
- Undefined: no counter; grant is held indefinitely while req is high.

Decomposition:
- Package obj_arb_pkg: state enum (IDLE/ARB/GRANT) and a shared ID-width constant type used by object cells and the arbiter.
- Sub-module obj_arb_contender, generated NUM_REQ times:
  - holds one active flag and selects ids[bitidx];
  - outputs its drive bit;
  - drops out on a mismatch with the resolved bit.
- The top level does the AND-reduction, FSM, winner encode and grant registers.

Test Plan:
1. Two contenders: NUM_REQ=2, ids={1101,0101}, req=11 at edge 0 -> bus_bit sequence 0,1,0,1; cell1 drops after the first bit; grant=01, grant_id=0101, arb_done at edge 5, no collision.
2. Duplicate IDs: ids 0101/0101, both req -> grant=01 (lowest index), collision and arb_done pulse together.
3. Release and rearbitrate: winner holds 10 cycles, then drops req while cell1 still requests -> grant clears, one IDLE cycle, new round, grant=10 after 5 more cycles.
4. Reset mid-operation: rst_n low during the second ARB cycle -> next edge all outputs are at reset values; the round restarts 1 cycle after rst_n returns high if req is still set.
5. Late request ignored: req1 rises during ARB with a lower ID 0000 -> cell0 is still granted; cell1 wins the following round.
6. ARB_TIMEOUT_EN defined, HOLD_MAX=16: winner holds req permanently -> grant drops after 16 cycles; with cell1 also requesting, the next round proceeds.
